alu_seq: RTL

//  Registered, parametrised successor to the 16-bit combinational ALU. Keeps the same 8-bit opcode set and adds:
//  - a WIDTH parameter;
//  - a persistent flag register (C,L,F,Z,N);
//  - a valid/ready input handshake;
//  - a multi-cycle iterative multiplier.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_iter.sv | 74 +++++++
 rtl/alu_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode encodings, flag bit positions and FSM states for alu_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_NOT  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_RSH  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_ALSH = 8'h0C;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_ARSH = 8'h0F;
  localparam logic [7:0] OP_LSH  = 8'h84;

  localparam int FLG_C = 4;
  localparam int FLG_L = 3;
  localparam int FLG_F = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ============================================================================
// alu_mul_iter : iterative shift-add unsigned multiplier, one bit per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_step;

  // Multiplier sits in the low half and shifts out as partial sums shift in.
  assign w_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign w_step = {w_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (busy_q) begin
      prod_d = w_step;
      cnt_d  = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = CNT_LOAD;
      mcand_d = a_i;
      prod_d  = {{WIDTH{1'b0}}, b_i};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = busy_q && (cnt_q == '0);
  assign product_o = w_step;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : registered ALU with flag register, valid/ready input and
//           multi-cycle multiplier
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic             out_valid,
  output logic [WIDTH-1:0] rout,
  output logic [4:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SH_LIMIT = WIDTH'(WIDTH);

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] rout_q, rout_d;
  logic [4:0]       flags_q, flags_d;
  logic             illegal_q, illegal_d;

  logic               w_accept, w_mul_start, w_mul_done, w_mul_busy;
  logic [2*WIDTH-1:0] w_product;
  logic               w_cin, w_add_ovf, w_sub_ovf, w_sh_big, w_upd_zn;
  logic [WIDTH:0]     w_add, w_sub;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH-1:0]   w_shl, w_shr, w_sar;

  assign w_accept    = in_valid && in_ready;
  assign w_mul_start = w_accept && (opcode == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clock     (clock),
    .reset     (reset),
    .start_i   (w_mul_start),
    .a_i       (r1),
    .b_i       (r2),
    .busy_o    (w_mul_busy),
    .done_o    (w_mul_done),
    .product_o (w_product)
  );

  // Carry-in only for ADDC/SUBC; it is the C flag left by the previous op.
  assign w_cin = ((opcode == OP_ADDC) || (opcode == OP_SUBC)) ? flags_q[FLG_C] : 1'b0;
  assign w_add = {1'b0, r1} + {1'b0, r2} + {{WIDTH{1'b0}}, w_cin};
  assign w_sub = {1'b0, r1} - {1'b0, r2} - {{WIDTH{1'b0}}, w_cin};
  assign w_add_ovf = (r1[MSB] == r2[MSB]) && (w_add[MSB] != r1[MSB]);
  assign w_sub_ovf = (r1[MSB] != r2[MSB]) && (w_sub[MSB] != r1[MSB]);

  assign w_sh_big = (r2 >= SH_LIMIT);
  assign w_sh     = r2[SHW-1:0];
  assign w_shl    = w_sh_big ? '0 : (r1 << w_sh);
  assign w_shr    = w_sh_big ? '0 : (r1 >> w_sh);
  assign w_sar    = w_sh_big ? {WIDTH{r1[MSB]}} : WIDTH'($signed(r1) >>> w_sh);

  always_comb begin
    rout_d      = rout_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    out_valid_d = 1'b0;
    w_upd_zn    = 1'b0;
    if (w_accept && (opcode != OP_MUL)) begin
      out_valid_d = 1'b1;
      illegal_d   = 1'b0;
      case (opcode)
        OP_AND:  rout_d = r1 & r2;
        OP_OR:   rout_d = r1 | r2;
        OP_XOR:  rout_d = r1 ^ r2;
        OP_NOT:  rout_d = ~r1;
        OP_ADD, OP_ADDC: begin
          rout_d         = w_add[WIDTH-1:0];
          flags_d[FLG_C] = w_add[WIDTH];
          flags_d[FLG_F] = w_add_ovf;
          w_upd_zn       = 1'b1;
        end
        OP_ADDU: begin
          rout_d         = w_add[WIDTH-1:0];
          flags_d[FLG_C] = w_add[WIDTH];
          w_upd_zn       = 1'b1;
        end
        OP_SUB, OP_SUBC: begin
          rout_d         = w_sub[WIDTH-1:0];
          flags_d[FLG_C] = w_sub[WIDTH];
          flags_d[FLG_F] = w_sub_ovf;
          w_upd_zn       = 1'b1;
        end
        OP_CMP: begin
          rout_d         = w_sub[WIDTH-1:0];
          flags_d[FLG_Z] = (r1 == r2);
          flags_d[FLG_L] = (r1 < r2);
          flags_d[FLG_N] = ($signed(r1) < $signed(r2));
        end
        OP_LSH, OP_ALSH: rout_d = w_shl;
        OP_RSH:          rout_d = w_shr;
        OP_ARSH:         rout_d = w_sar;
        default: begin
          rout_d    = '0;
          illegal_d = 1'b1;
        end
      endcase
    end else if (w_mul_done) begin
      out_valid_d    = 1'b1;
      illegal_d      = 1'b0;
      rout_d         = w_product[WIDTH-1:0];
      flags_d[FLG_F] = |w_product[2*WIDTH-1:WIDTH];
      w_upd_zn       = 1'b1;
    end
    if (w_upd_zn) begin
      flags_d[FLG_Z] = (rout_d == '0);
      flags_d[FLG_N] = rout_d[MSB];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_mul_start) state_d = ST_MUL;
      ST_MUL:  if (w_mul_done || !w_mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      rout_q      <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      rout_q      <= rout_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign rout      = rout_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire
